// File: rtl/cbf_sched_pkg.sv
// Shared types and constants for the batch scheduler: FSM states, bank index
// type and the banking/priming constants.
package cbf_sched_pkg;

    localparam int NUM_BANKS     = 4;
    localparam int PRIME_BATCHES = 3;

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BUSY  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/mod_counter.sv
// Enabled modulo-N counter with a registered count and a same-cycle wrap flag
// (wrap is high when the enabled increment rolls N-1 back to 0).
module mod_counter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clkIn,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        wrap    = en && (count_q == W'(N - 1));
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/batch_scheduler.sv
// Sample-buffer write sequencer: rotates four banks per batch, decimates the
// sample stream and hands finished batches to the compute engine.
module batch_scheduler
    import cbf_sched_pkg::*;
#(
    parameter  int DSR   = 1,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int DW    = (DSR > 1) ? $clog2(DSR) : 1
) (
    input  logic          clkIn,
    input  logic          rst,
    input  logic          smpValid,
    input  logic          calcDone,
    output logic [AW-1:0] wrAddr,
    output logic [1:0]    wrBank,
    output logic [1:0]    lookaheadBank,
    output logic [1:0]    calcBank,
    output logic [1:0]    lookbackBank,
    output logic          calcStart,
    output logic          decimStrobe,
    output logic [DW-1:0] decimCnt,
    output logic          overrun,
    output logic [1:0]    state
);

    logic addrWrap;
    logic decWrap;

    mod_counter #(.N(DEPTH), .W(AW)) u_addr_cnt (
        .clkIn (clkIn),
        .rst   (rst),
        .en    (smpValid),
        .count (wrAddr),
        .wrap  (addrWrap)
    );

    mod_counter #(.N(DSR), .W(DW)) u_decim_cnt (
        .clkIn (clkIn),
        .rst   (rst),
        .en    (smpValid),
        .count (decimCnt),
        .wrap  (decWrap)
    );

    bank_t        wrBank_d,      wrBank_q;
    logic         calcStart_d,   calcStart_q;
    logic         decimStrobe_d, decimStrobe_q;
    logic         overrun_d,     overrun_q;
    logic [1:0]   primeCnt_d,    primeCnt_q;
    sched_state_e state_d,       state_q;

    always_comb begin
        wrBank_d      = wrBank_q;
        decimStrobe_d = decWrap;
        calcStart_d   = 1'b0;
        overrun_d     = overrun_q;
        primeCnt_d    = primeCnt_q;
        state_d       = state_q;

        if (addrWrap) begin
            wrBank_d = wrBank_q + bank_t'(1);
        end

        case (state_q)
            ST_PRIME: begin
                if (addrWrap) begin
                    if (primeCnt_q == 2'(PRIME_BATCHES - 1)) begin
                        calcStart_d = 1'b1;
                        primeCnt_d  = '0;
                        state_d     = ST_BUSY;
                    end else begin
                        primeCnt_d = primeCnt_q + 2'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (addrWrap) begin
                    calcStart_d = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion coinciding with a boundary frees the engine just in time.
                if (calcDone) begin
                    if (addrWrap) begin
                        calcStart_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (addrWrap) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                primeCnt_d = '0;
                state_d    = ST_PRIME;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (!rst) begin
            wrBank_q      <= '0;
            calcStart_q   <= 1'b0;
            decimStrobe_q <= 1'b0;
            overrun_q     <= 1'b0;
            primeCnt_q    <= '0;
            state_q       <= ST_PRIME;
        end else begin
            wrBank_q      <= wrBank_d;
            calcStart_q   <= calcStart_d;
            decimStrobe_q <= decimStrobe_d;
            overrun_q     <= overrun_d;
            primeCnt_q    <= primeCnt_d;
            state_q       <= state_d;
        end
    end

    assign wrBank        = wrBank_q;
    assign lookaheadBank = wrBank_q - bank_t'(1);
    assign calcBank      = wrBank_q - bank_t'(2);
    assign lookbackBank  = wrBank_q - bank_t'(3);
    assign calcStart     = calcStart_q;
    assign decimStrobe   = decimStrobe_q;
    assign overrun       = overrun_q;
    assign state         = state_q;

endmodule

// File: tb/tb_batch_scheduler.sv
// Bench for batch_scheduler: two instances (DSR=4/DEPTH=8 and DSR=1/DEPTH=2)
// checked every cycle against a sample-count model plus directed literals.
module tb_batch_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA = 1'b0, smpA = 1'b0, doneA = 1'b0;
    logic [2:0] wrAddrA;
    logic [1:0] wrBankA, laA, cbA, lbA, stateA, decCntA;
    logic       startA, strbA, ovrA;

    logic       rstB = 1'b0, smpB = 1'b0, doneB = 1'b0;
    logic [0:0] wrAddrB, decCntB;
    logic [1:0] wrBankB, laB, cbB, lbB, stateB;
    logic       startB, strbB, ovrB;

    batch_scheduler #(.DSR(4), .DEPTH(8)) dutA (
        .clkIn(clk), .rst(rstA), .smpValid(smpA), .calcDone(doneA),
        .wrAddr(wrAddrA), .wrBank(wrBankA), .lookaheadBank(laA), .calcBank(cbA),
        .lookbackBank(lbA), .calcStart(startA), .decimStrobe(strbA),
        .decimCnt(decCntA), .overrun(ovrA), .state(stateA)
    );

    batch_scheduler #(.DSR(1), .DEPTH(2)) dutB (
        .clkIn(clk), .rst(rstB), .smpValid(smpB), .calcDone(doneB),
        .wrAddr(wrAddrB), .wrBank(wrBankB), .lookaheadBank(laB), .calcBank(cbB),
        .lookbackBank(lbB), .calcStart(startB), .decimStrobe(strbB),
        .decimCnt(decCntB), .overrun(ovrB), .state(stateB)
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: everything follows from the count of accepted samples since reset
    // and from whether the engine currently holds a batch.
    int acc [2];
    int nb  [2];
    bit busy[2], ever[2], ovr[2], eStart[2], eStrb[2], armed[2];
    int depthOf [2] = '{8, 2};
    int dsrOf   [2] = '{4, 1};
    bit ms, md, mr, mb;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ms = (k == 0) ? smpA  : smpB;
            md = (k == 0) ? doneA : doneB;
            mr = (k == 0) ? rstA  : rstB;
            if (!mr) begin
                acc[k] = 0; nb[k] = 0; busy[k] = 0; ever[k] = 0;
                ovr[k] = 0; eStart[k] = 0; eStrb[k] = 0; armed[k] = 1;
            end else begin
                eStart[k] = 0;
                mb = ms && (acc[k] % depthOf[k] == depthOf[k] - 1);
                if (ms) acc[k]++;
                eStrb[k] = ms && (acc[k] % dsrOf[k] == 0);
                if (mb) nb[k]++;
                if (busy[k] && md) begin
                    if (mb) eStart[k] = 1;
                    else    busy[k]   = 0;
                end else if (busy[k] && mb) begin
                    ovr[k] = 1;
                end else if (!busy[k] && mb && (ever[k] || nb[k] == 3)) begin
                    eStart[k] = 1; busy[k] = 1; ever[k] = 1;
                end
            end
        end
    end

    function automatic int exp_state(int k);
        return !ever[k] ? 0 : (busy[k] ? 2 : 1);
    endfunction

    function automatic int exp_bank(int k, int off);
        return ((acc[k] / depthOf[k]) + off) % 4;
    endfunction

    always @(negedge clk) begin
        if (armed[0]) begin
            cmp("A.wrAddr", wrAddrA, acc[0] % 8);
            cmp("A.wrBank", wrBankA, exp_bank(0, 0));
            cmp("A.lookahead", laA, exp_bank(0, 3));
            cmp("A.calcBank", cbA, exp_bank(0, 2));
            cmp("A.lookback", lbA, exp_bank(0, 1));
            cmp("A.decimCnt", decCntA, acc[0] % 4);
            cmp("A.decimStrobe", strbA, eStrb[0]);
            cmp("A.calcStart", startA, eStart[0]);
            cmp("A.overrun", ovrA, ovr[0]);
            cmp("A.state", stateA, exp_state(0));
        end
        if (armed[1]) begin
            cmp("B.wrAddr", wrAddrB, acc[1] % 2);
            cmp("B.wrBank", wrBankB, exp_bank(1, 0));
            cmp("B.calcBank", cbB, exp_bank(1, 2));
            cmp("B.decimCnt", decCntB, 0);
            cmp("B.decimStrobe", strbB, eStrb[1]);
            cmp("B.calcStart", startB, eStart[1]);
            cmp("B.overrun", ovrB, ovr[1]);
            cmp("B.state", stateB, exp_state(1));
        end
    end

    int sinceA = 1000;

    task automatic stepA(input logic s, input logic d);
        smpA  = s;
        doneA = d;
        @(posedge clk);
        #1;
        sinceA = startA ? 0 : sinceA + 1;
    endtask

    // dly < 0: never answer; otherwise pulse calcDone dly cycles after calcStart.
    task automatic runA(input int n, input int dly, input bit tog);
        for (int i = 0; i < n; i++) begin
            stepA(tog ? (i % 2 == 0) : 1'b1, (dly >= 0) && (sinceA == dly));
        end
        smpA  = 1'b0;
        doneA = 1'b0;
    endtask

    task automatic check_reset_A(input string tag);
        cmp({tag, ".rst.wrAddr"}, wrAddrA, 0);
        cmp({tag, ".rst.wrBank"}, wrBankA, 0);
        cmp({tag, ".rst.lookahead"}, laA, 3);
        cmp({tag, ".rst.calcBank"}, cbA, 2);
        cmp({tag, ".rst.lookback"}, lbA, 1);
        cmp({tag, ".rst.decimCnt"}, decCntA, 0);
        cmp({tag, ".rst.calcStart"}, startA, 0);
        cmp({tag, ".rst.decimStrobe"}, strbA, 0);
        cmp({tag, ".rst.overrun"}, ovrA, 0);
        cmp({tag, ".rst.state"}, stateA, 0);
    endtask

    bit bDone = 0;

    initial begin
        rstB = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstB = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            smpB = 1'b1;
            @(posedge clk);
            #1;
            cmp("B.dir.strobe", strbB, 1);
            cmp("B.dir.decimCnt", decCntB, 0);
            cmp("B.dir.start", startB, (i == 6));
        end
        cmp("B.dir.calcBank", cbB, 1);
        doneB = 1'b1;
        @(posedge clk);
        #1;
        doneB = 1'b0;
        cmp("B.dir.stateWait", stateB, 1);
        @(posedge clk);
        #1;
        smpB = 1'b0;
        cmp("B.dir.restart", startB, 1);
        bDone = 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstA = 1'b0;
        stepA(1'b1, 1'b0);
        stepA(1'b0, 1'b0);
        rstA = 1'b1;
        check_reset_A("A0");

        // Priming: three boundaries before the first hand-off.
        runA(23, -1, 1'b0);
        cmp("A.dir.noStart23", startA, 0);
        cmp("A.dir.state23", stateA, 0);
        runA(1, -1, 1'b0);
        cmp("A.dir.start24", startA, 1);
        cmp("A.dir.calcBank24", cbA, 1);
        cmp("A.dir.wrBank24", wrBankA, 3);
        cmp("A.dir.strobe24", strbA, 1);
        cmp("A.dir.state24", stateA, 2);

        // Engine keeps up.
        runA(32, 2, 1'b0);
        cmp("A.dir.start56", startA, 1);
        cmp("A.dir.ovr56", ovrA, 0);

        // Engine misses a boundary.
        runA(8, -1, 1'b0);
        cmp("A.dir.ovrSet", ovrA, 1);
        cmp("A.dir.noStartDrop", startA, 0);
        cmp("A.dir.stillBusy", stateA, 2);
        stepA(1'b0, 1'b1);
        cmp("A.dir.toWait", stateA, 1);
        runA(8, -1, 1'b0);
        cmp("A.dir.startAfterWait", startA, 1);
        cmp("A.dir.ovrSticky", ovrA, 1);

        rstA = 1'b0;
        stepA(1'b0, 1'b0);
        stepA(1'b0, 1'b0);
        rstA = 1'b1;
        check_reset_A("A1");

        // Completion coincident with a boundary sample.
        runA(24, -1, 1'b0);
        runA(7, -1, 1'b0);
        stepA(1'b1, 1'b1);
        smpA  = 1'b0;
        doneA = 1'b0;
        cmp("A.dir.coinStart", startA, 1);
        cmp("A.dir.coinState", stateA, 2);
        cmp("A.dir.coinOvr", ovrA, 0);
        cmp("A.dir.coinAddr", wrAddrA, 0);

        // Gapped samples, then reset while busy.
        runA(10, -1, 1'b1);
        cmp("A.dir.gapAddr", wrAddrA, 5);
        cmp("A.dir.gapDecim", decCntA, 1);
        cmp("A.dir.gapState", stateA, 2);
        rstA = 1'b0;
        stepA(1'b1, 1'b0);
        stepA(1'b0, 1'b0);
        rstA = 1'b1;
        check_reset_A("A2");
        stepA(1'b1, 1'b0);
        smpA = 1'b0;
        cmp("A.dir.postRstAddr", wrAddrA, 1);
        cmp("A.dir.postRstBank", wrBankA, 0);

        wait (bDone);
        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
